// File: rtl/cbm_pkg.sv
// Shared types for the CBM issue arbiter: FSM encoding, request record and port id width.
package cbm_pkg;

  typedef enum logic {
    CBM_ARB_IDLE = 1'b0,
    CBM_ARB_WAIT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } cbm_req_t;

  localparam int PORT_ID_W = 1;
  localparam int REQ_W     = $bits(cbm_req_t);

endpackage

// File: rtl/cbm_req_fifo.sv
// Per-port request FIFO holding queued multiply ops; supports simultaneous push and pop.
module cbm_req_fifo
  import cbm_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  cbm_req_t push_data,
  output cbm_req_t head,
  output logic     full,
  output logic     empty
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  cbm_req_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign head    = mem[rd_ptr_q];
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;

  // Depth is a power of two, so pointer increments wrap on their own.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/cbm_issue_arbiter.sv
// Shares one column-bypass multiplier between two issue pipes with round-robin issue
// and tagged, registered writeback of each result.
module cbm_issue_arbiter
  import cbm_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req0_valid_i,
  output logic        req0_ready_o,
  input  logic [31:0] req0_a_i,
  input  logic [31:0] req0_b_i,
  input  logic [4:0]  req0_rd_i,
  input  logic        req1_valid_i,
  output logic        req1_ready_o,
  input  logic [31:0] req1_a_i,
  input  logic [31:0] req1_b_i,
  input  logic [4:0]  req1_rd_i,
  input  logic        flush_i,
  output logic        mul_start_o,
  output logic [31:0] mul_a_o,
  output logic [31:0] mul_b_o,
  output logic [4:0]  mul_rd_o,
  input  logic        mul_done_i,
  input  logic [31:0] mul_result_i,
  input  logic [4:0]  mul_rd_i,
  output logic        wb_valid_o,
  output logic        wb_port_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_result_o,
  output logic        busy_o
);

  arb_state_e           state_q, state_d;
  logic                 discard_q, discard_d;
  logic [PORT_ID_W-1:0] inflight_q, inflight_d;
  logic [PORT_ID_W-1:0] rr_q, rr_d;
  logic [PORT_ID_W-1:0] grant;

  cbm_req_t push0_data, push1_data, head0, head1, head_sel;
  logic     push0, push1, pop0, pop1;
  logic     full0, full1, empty0, empty1;
  logic     issue, wb_fire;

  assign req0_ready_o = rst_ni & ~full0 & ~flush_i;
  assign req1_ready_o = rst_ni & ~full1 & ~flush_i;

  // rd=0 ops have no architectural effect, so they are acknowledged but never queued.
  assign push0 = req0_valid_i & req0_ready_o & (req0_rd_i != '0);
  assign push1 = req1_valid_i & req1_ready_o & (req1_rd_i != '0);

  assign push0_data = '{a: req0_a_i, b: req0_b_i, rd: req0_rd_i};
  assign push1_data = '{a: req1_a_i, b: req1_b_i, rd: req1_rd_i};

  cbm_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo0 (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (push0),
    .pop      (pop0),
    .flush    (flush_i),
    .push_data(push0_data),
    .head     (head0),
    .full     (full0),
    .empty    (empty0)
  );

  cbm_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo1 (
    .clk      (clk_i),
    .rst_n    (rst_ni),
    .push     (push1),
    .pop      (pop1),
    .flush    (flush_i),
    .push_data(push1_data),
    .head     (head1),
    .full     (full1),
    .empty    (empty1)
  );

  // The CBM goes idle in the cycle it raises done, so a new op may start in that same cycle.
  assign issue = ((state_q == CBM_ARB_IDLE) || ((state_q == CBM_ARB_WAIT) && mul_done_i))
                 && (!empty0 || !empty1) && !flush_i;

  always_comb begin
    grant = '0;
    if (!empty0 && !empty1) grant = rr_q;
    else if (!empty1)       grant = 1'b1;
  end

  assign pop0     = issue & (grant == 1'b0);
  assign pop1     = issue & (grant == 1'b1);
  assign head_sel = (grant == 1'b1) ? head1 : head0;

  assign mul_start_o = issue;
  assign mul_a_o     = issue ? head_sel.a  : '0;
  assign mul_b_o     = issue ? head_sel.b  : '0;
  assign mul_rd_o    = issue ? head_sel.rd : '0;

  always_comb begin
    state_d    = state_q;
    discard_d  = discard_q;
    inflight_d = inflight_q;
    rr_d       = rr_q;
    if (issue) begin
      state_d    = CBM_ARB_WAIT;
      discard_d  = 1'b0;
      inflight_d = grant;
      rr_d       = ~grant;
    end else if (state_q == CBM_ARB_WAIT) begin
      if (mul_done_i)   state_d   = CBM_ARB_IDLE;
      else if (flush_i) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= CBM_ARB_IDLE;
      discard_q  <= 1'b0;
      inflight_q <= '0;
      rr_q       <= '0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      inflight_q <= inflight_d;
      rr_q       <= rr_d;
    end
  end

  // A flush arriving with done drops that result as well as any earlier-flushed op.
  assign wb_fire = (state_q == CBM_ARB_WAIT) & mul_done_i & ~discard_q & ~flush_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wb_valid_o  <= 1'b0;
      wb_port_o   <= 1'b0;
      wb_rd_o     <= '0;
      wb_result_o <= '0;
    end else begin
      wb_valid_o <= wb_fire;
      if (wb_fire) begin
        wb_port_o   <= inflight_q;
        wb_rd_o     <= mul_rd_i;
        wb_result_o <= mul_result_i;
      end
    end
  end

  assign busy_o = !empty0 || !empty1 || (state_q == CBM_ARB_WAIT);

endmodule

// File: tb/tb_cbm_issue_arbiter.sv
// Directed bench for cbm_issue_arbiter; the bench plays the CBM by driving done/result by hand.
module tb_cbm_issue_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [4:0]  req0_rd = '0, req1_rd = '0;
  logic        flush = 1'b0;
  logic        mul_start;
  logic [31:0] mul_a, mul_b;
  logic [4:0]  mul_rd;
  logic        mul_done = 1'b0;
  logic [31:0] mul_result = '0;
  logic [4:0]  mul_done_rd = '0;
  logic        wb_valid, wb_port, busy;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cbm_issue_arbiter #(.FIFO_DEPTH(2)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req0_valid_i(req0_valid),
    .req0_ready_o(req0_ready),
    .req0_a_i    (req0_a),
    .req0_b_i    (req0_b),
    .req0_rd_i   (req0_rd),
    .req1_valid_i(req1_valid),
    .req1_ready_o(req1_ready),
    .req1_a_i    (req1_a),
    .req1_b_i    (req1_b),
    .req1_rd_i   (req1_rd),
    .flush_i     (flush),
    .mul_start_o (mul_start),
    .mul_a_o     (mul_a),
    .mul_b_o     (mul_b),
    .mul_rd_o    (mul_rd),
    .mul_done_i  (mul_done),
    .mul_result_i(mul_result),
    .mul_rd_i    (mul_done_rd),
    .wb_valid_o  (wb_valid),
    .wb_port_o   (wb_port),
    .wb_rd_o     (wb_rd),
    .wb_result_o (wb_result),
    .busy_o      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_stimulus(input int port, input logic v, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd);
    if (port == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_rd = rd;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_rd = rd;
    end
  endtask

  task automatic cbm_done(input logic d, input logic [31:0] res, input logic [4:0] rd);
    mul_done = d; mul_result = res; mul_done_rd = rd;
  endtask

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_start(input string tag, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] rd);
    check_output({tag, "_start"}, {31'd0, mul_start}, 32'd1);
    check_output({tag, "_a"}, mul_a, a);
    check_output({tag, "_b"}, mul_b, b);
    check_output({tag, "_rd"}, {27'd0, mul_rd}, {27'd0, rd});
  endtask

  task automatic check_wb(input string tag, input logic port, input logic [4:0] rd,
                          input logic [31:0] res);
    check_output({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    check_output({tag, "_wbport"}, {31'd0, wb_port}, {31'd0, port});
    check_output({tag, "_wbrd"}, {27'd0, wb_rd}, {27'd0, rd});
    check_output({tag, "_wbres"}, wb_result, res);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply_stimulus(0, 1'b0, '0, '0, '0);
    apply_stimulus(1, 1'b0, '0, '0, '0);
    cbm_done(1'b0, '0, '0);
    flush = 1'b0;
    #1;
    check_output("rst_ready0", {31'd0, req0_ready}, 32'd0);
    check_output("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check_output("rst_busy", {31'd0, busy}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    check_output("post_rst_ready0", {31'd0, req0_ready}, 32'd1);
    check_output("post_rst_ready1", {31'd0, req1_ready}, 32'd1);
    check_output("post_rst_start", {31'd0, mul_start}, 32'd0);
  endtask

  initial begin
    $display("[TB] start");
    do_reset();

    // Single port-0 op through the whole pipe.
    apply_stimulus(0, 1'b1, 32'd7, 32'd6, 5'd3);
    #1 check_output("t1_nostart", {31'd0, mul_start}, 32'd0);
    tick();
    apply_stimulus(0, 1'b0, '0, '0, '0);
    #1 check_start("t1", 32'd7, 32'd6, 5'd3);
    check_output("t1_busy", {31'd0, busy}, 32'd1);
    tick(); tick();
    cbm_done(1'b1, 32'd42, 5'd3);
    #1 check_output("t1_done_nostart", {31'd0, mul_start}, 32'd0);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t1", 1'b0, 5'd3, 32'd42);
    check_output("t1_idle", {31'd0, busy}, 32'd0);
    tick();
    check_output("t1_pulse", {31'd0, wb_valid}, 32'd0);

    // Round-robin over two ops per port, starting from a fresh pointer.
    do_reset();
    apply_stimulus(0, 1'b1, 32'd2, 32'd3, 5'd1);
    apply_stimulus(1, 1'b1, 32'hFFFF_FFFE, 32'd3, 5'd2);
    tick();
    apply_stimulus(0, 1'b1, 32'd4, 32'd5, 5'd4);
    apply_stimulus(1, 1'b1, 32'd9, 32'd9, 5'd5);
    #1 check_start("t2_op1", 32'd2, 32'd3, 5'd1);
    tick();
    apply_stimulus(0, 1'b0, '0, '0, '0);
    apply_stimulus(1, 1'b0, '0, '0, '0);
    tick();
    cbm_done(1'b1, 32'd6, 5'd1);
    #1 check_start("t2_op2", 32'hFFFF_FFFE, 32'd3, 5'd2);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t2_r1", 1'b0, 5'd1, 32'd6);
    tick();
    cbm_done(1'b1, 32'hFFFF_FFFA, 5'd2);
    #1 check_start("t2_op3", 32'd4, 32'd5, 5'd4);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t2_r2", 1'b1, 5'd2, 32'hFFFF_FFFA);
    tick();
    cbm_done(1'b1, 32'd20, 5'd4);
    #1 check_start("t2_op4", 32'd9, 32'd9, 5'd5);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t2_r3", 1'b0, 5'd4, 32'd20);
    tick();
    cbm_done(1'b1, 32'd81, 5'd5);
    #1 check_output("t2_nostart", {31'd0, mul_start}, 32'd0);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t2_r4", 1'b1, 5'd5, 32'd81);
    check_output("t2_idle", {31'd0, busy}, 32'd0);

    // Zero-operand op with 2-cycle latency, next op issued on the done cycle.
    tick();
    apply_stimulus(0, 1'b1, 32'd0, 32'd5, 5'd6);
    tick();
    apply_stimulus(0, 1'b1, 32'd3, 32'd4, 5'd7);
    #1 check_start("t3_op1", 32'd0, 32'd5, 5'd6);
    tick();
    apply_stimulus(0, 1'b0, '0, '0, '0);
    #1 check_output("t3_gap", {31'd0, mul_start}, 32'd0);
    tick();
    cbm_done(1'b1, 32'd0, 5'd6);
    #1 check_start("t3_b2b", 32'd3, 32'd4, 5'd7);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t3_r1", 1'b0, 5'd6, 32'd0);
    check_output("t3_busy", {31'd0, busy}, 32'd1);
    tick();
    cbm_done(1'b1, 32'd12, 5'd7);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t3_r2", 1'b0, 5'd7, 32'd12);

    // Fill port 1 while the CBM is busy; order must survive the full condition.
    tick();
    apply_stimulus(1, 1'b1, 32'd1, 32'd1, 5'd8);
    tick();
    apply_stimulus(1, 1'b1, 32'd2, 32'd2, 5'd9);
    #1 check_start("t4_a", 32'd1, 32'd1, 5'd8);
    tick();
    apply_stimulus(1, 1'b1, 32'd3, 32'd3, 5'd10);
    #1 check_output("t4_ready_one", {31'd0, req1_ready}, 32'd1);
    tick();
    apply_stimulus(1, 1'b1, 32'd4, 32'd4, 5'd11);
    #1 check_output("t4_full", {31'd0, req1_ready}, 32'd0);
    tick();
    cbm_done(1'b1, 32'd1, 5'd8);
    #1 check_output("t4_full_pop", {31'd0, req1_ready}, 32'd0);
    check_start("t4_b", 32'd2, 32'd2, 5'd9);
    tick();
    cbm_done(1'b1, 32'd4, 5'd9);
    #1 check_output("t4_ready_back", {31'd0, req1_ready}, 32'd1);
    check_start("t4_c", 32'd3, 32'd3, 5'd10);
    check_wb("t4_ra", 1'b1, 5'd8, 32'd1);
    tick();
    apply_stimulus(1, 1'b0, '0, '0, '0);
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t4_rb", 1'b1, 5'd9, 32'd4);
    check_output("t4_nostart", {31'd0, mul_start}, 32'd0);
    tick();
    cbm_done(1'b1, 32'd9, 5'd10);
    #1 check_start("t4_d", 32'd4, 32'd4, 5'd11);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t4_rc", 1'b1, 5'd10, 32'd9);
    tick();
    cbm_done(1'b1, 32'd16, 5'd11);
    #1 check_output("t4_end_nostart", {31'd0, mul_start}, 32'd0);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t4_rd", 1'b1, 5'd11, 32'd16);
    check_output("t4_idle", {31'd0, busy}, 32'd0);

    // Flush while waiting with two ops queued.
    tick();
    apply_stimulus(0, 1'b1, 32'd5, 32'd5, 5'd12);
    tick();
    apply_stimulus(0, 1'b1, 32'd6, 32'd6, 5'd13);
    apply_stimulus(1, 1'b1, 32'd7, 32'd7, 5'd14);
    #1 check_start("t5_a", 32'd5, 32'd5, 5'd12);
    tick();
    apply_stimulus(0, 1'b0, '0, '0, '0);
    apply_stimulus(1, 1'b0, '0, '0, '0);
    flush = 1'b1;
    #1 check_output("t5_flush_ready0", {31'd0, req0_ready}, 32'd0);
    check_output("t5_flush_ready1", {31'd0, req1_ready}, 32'd0);
    tick();
    flush = 1'b0;
    #1 check_output("t5_still_busy", {31'd0, busy}, 32'd1);
    tick();
    cbm_done(1'b1, 32'd25, 5'd12);
    #1 check_output("t5_empty_nostart", {31'd0, mul_start}, 32'd0);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_output("t5_no_wb", {31'd0, wb_valid}, 32'd0);
    check_output("t5_idle", {31'd0, busy}, 32'd0);
    apply_stimulus(0, 1'b1, 32'd3, 32'd3, 5'd15);
    tick();
    apply_stimulus(0, 1'b0, '0, '0, '0);
    #1 check_start("t5_new", 32'd3, 32'd3, 5'd15);
    tick(); tick();
    cbm_done(1'b1, 32'd9, 5'd15);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_wb("t5_new", 1'b0, 5'd15, 32'd9);

    // Flush coincident with done: result dropped, queued op not started.
    apply_stimulus(1, 1'b1, 32'd2, 32'd2, 5'd16);
    tick();
    apply_stimulus(1, 1'b1, 32'd3, 32'd3, 5'd17);
    #1 check_start("t5b", 32'd2, 32'd2, 5'd16);
    tick();
    apply_stimulus(1, 1'b0, '0, '0, '0);
    tick();
    cbm_done(1'b1, 32'd4, 5'd16);
    flush = 1'b1;
    #1 check_output("t5b_nostart", {31'd0, mul_start}, 32'd0);
    tick();
    cbm_done(1'b0, '0, '0);
    flush = 1'b0;
    #1 check_output("t5b_no_wb", {31'd0, wb_valid}, 32'd0);
    check_output("t5b_idle", {31'd0, busy}, 32'd0);

    // rd=0 request is acknowledged but never issued.
    tick();
    apply_stimulus(0, 1'b1, 32'd9, 32'd9, 5'd0);
    #1 check_output("t6_rd0_ready", {31'd0, req0_ready}, 32'd1);
    tick();
    apply_stimulus(0, 1'b0, '0, '0, '0);
    #1 check_output("t6_rd0_nostart", {31'd0, mul_start}, 32'd0);
    check_output("t6_rd0_idle", {31'd0, busy}, 32'd0);

    // Reset in the middle of WAIT, then a stray done must not produce writeback.
    tick();
    apply_stimulus(0, 1'b1, 32'd2, 32'd2, 5'd18);
    tick();
    apply_stimulus(0, 1'b0, '0, '0, '0);
    #1 check_start("t6_w", 32'd2, 32'd2, 5'd18);
    tick();
    rst_n = 1'b0;
    #1 check_output("t6_rst_busy", {31'd0, busy}, 32'd0);
    check_output("t6_rst_ready", {31'd0, req0_ready}, 32'd0);
    check_output("t6_rst_a", mul_a, 32'd0);
    tick();
    rst_n = 1'b1;
    cbm_done(1'b1, 32'd4, 5'd18);
    #1 check_output("t6_stray_nostart", {31'd0, mul_start}, 32'd0);
    tick();
    cbm_done(1'b0, '0, '0);
    #1 check_output("t6_stale_wb", {31'd0, wb_valid}, 32'd0);
    check_output("t6_final_idle", {31'd0, busy}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
